// File: rtl/lz77_deflate_mapper.sv
// lz77_deflate_mapper
// Turns LZ77 triples (position, length, next symbol) into DEFLATE lit/len and
// distance symbols with extra bits, one symbol per valid/ready handshake.
// Tokens are buffered in a small FIFO. Matches shorter than 3 bytes are
// re-expanded into literals from a local history window.
// Optional feature macro: LZ77_MAPPER_EOB_EN adds a flush input. A flush makes
// the block emit end-of-block code 256 and then reset the history pointer.
module lz77_deflate_mapper #(
  parameter int DATA_WIDTH           = 8,
  parameter int DICTIONARY_DEPTH     = 32,
  parameter int DICTIONARY_DEPTH_LOG = 5,
  parameter int CNT_WIDTH            = 5,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            output_enable,
  input  logic [DICTIONARY_DEPTH_LOG-1:0] match_position,
  input  logic [CNT_WIDTH-1:0]            match_length,
  input  logic [DATA_WIDTH-1:0]           next_symbol,
`ifdef LZ77_MAPPER_EOB_EN
  input  logic                            flush,
`endif
  output logic                            sym_valid,
  input  logic                            sym_ready,
  output logic                            sym_is_dist,
  output logic [8:0]                      sym_code,
  output logic [4:0]                      sym_extra,
  output logic [2:0]                      sym_extra_len,
  output logic                            fifo_overflow
);
  localparam int DL  = DICTIONARY_DEPTH_LOG;
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int CW  = FAW + 1;
  localparam logic [DL-1:0]  A_ONE   = 1;
  localparam logic [FAW-1:0] PTR_ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DIST, S_COPY, S_SHORT, S_LIT, S_EOB} state_t;

  typedef struct packed {
    logic [DL-1:0]         pos;
    logic [CNT_WIDTH-1:0]  len;
    logic [DATA_WIDTH-1:0] sym;
  } tok_t;

  typedef struct packed {
    logic       is_dist;
    logic [8:0] code;
    logic [4:0] extra;
    logic [2:0] elen;
  } sym_t;

  // Returns the index of the highest set bit. A zero input returns 0.
  function automatic logic [2:0] msb_idx(input logic [5:0] v);
    msb_idx = '0;
    for (int i = 0; i < 6; i++) if (v[i]) msb_idx = 3'(i);
  endfunction

  // Computes the length symbol. After l = len-3, each extra bit doubles the
  // bucket width. Each bucket size holds four codes.
  function automatic sym_t len_sym(input logic [CNT_WIDTH-1:0] len);
    logic [5:0] l;
    logic [2:0] eb;
    len_sym = '0;
    l = 6'(len) - 6'd3;
    if (l < 6'd8) begin
      len_sym.code = 9'd257 + 9'(l);
    end else begin
      eb = msb_idx(l) - 3'd2;
      len_sym.code  = 9'd257 + {4'd0, eb, 2'b00} + 9'(l >> eb);
      len_sym.extra = 5'(l & ~(6'h3f << eb));
      len_sym.elen  = eb;
    end
  endfunction

  // Computes the distance symbol. With dd = distance-1 = pos, each bucket size
  // holds two codes.
  function automatic sym_t dist_sym(input logic [DL-1:0] pos);
    logic [5:0] dd;
    logic [2:0] eb;
    dist_sym = '0;
    dist_sym.is_dist = 1'b1;
    dd = 6'(pos);
    if (dd < 6'd4) begin
      dist_sym.code = 9'(dd);
    end else begin
      eb = msb_idx(dd) - 3'd1;
      dist_sym.code  = {5'd0, eb, 1'b0} + 9'(dd >> eb);
      dist_sym.extra = 5'(dd & ~(6'h3f << eb));
      dist_sym.elen  = eb;
    end
  endfunction

  function automatic sym_t lit_sym(input logic [DATA_WIDTH-1:0] b);
    lit_sym = '0;
    lit_sym.code = 9'(b);
  endfunction

  tok_t                  fifo_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] hist_q [DICTIONARY_DEPTH];
  logic [FAW-1:0]        rd_q, wr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q;
  state_t                state_q, state_d;
  tok_t                  cur_q, cur_d, head;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [DL-1:0]         wp_q, wp_d;
  sym_t                  out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  empty, full, pop, push_ok, fire;
  logic                  hist_we, eob_go, eob_done;
  logic [DATA_WIDTH-1:0] hist_wd, head_byte, cur_byte;
`ifdef LZ77_MAPPER_EOB_EN
  logic                  flush_pend_q;
  logic [CW-1:0]         flush_left_q;
`endif

  assign head      = fifo_q[rd_q];
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign fire      = valid_q && sym_ready;
  assign push_ok   = output_enable && (!full || pop);
  assign cnt_d     = cnt_q + CW'(push_ok) - CW'(pop);
  assign head_byte = hist_q[wp_q - head.pos - A_ONE];
  assign cur_byte  = hist_q[wp_q - cur_q.pos - A_ONE];

  // Token storage. Only the pointers need a reset.
  // NOTE: memory arrays are left unreset; a reset would turn them into wide flop banks with reset muxes for no functional gain.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_q] <= '{pos: match_position, len: match_length, sym: next_symbol};
  end

  // History window write port. Every byte is written when it is produced.
  always_ff @(posedge clk) begin
    if (hist_we) hist_q[wp_q] <= hist_wd;
  end

  // Next-state, symbol generation and history write requests.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d  = state_q;
    cur_d    = cur_q;
    rem_d    = rem_q;
    wp_d     = wp_q;
    out_d    = out_q;
    valid_d  = valid_q;
    pop      = 1'b0;
    hist_we  = 1'b0;
    hist_wd  = '0;
    eob_go   = 1'b0;
    eob_done = 1'b0;
`ifdef LZ77_MAPPER_EOB_EN
    eob_go = (state_q == S_IDLE) && flush_pend_q && (flush_left_q == '0);
`endif
    case (state_q)
      S_IDLE: begin
        if (eob_go) begin
          out_d      = '0;
          out_d.code = 9'd256;
          valid_d    = 1'b1;
          state_d    = S_EOB;
        end else if (!empty) begin
          pop   = 1'b1;
          cur_d = head;
          valid_d = 1'b1;
          if (head.len >= CNT_WIDTH'(3)) begin
            out_d   = len_sym(head.len);
            state_d = S_LEN;
          end else if (head.len != '0) begin
            out_d   = lit_sym(head_byte);
            hist_we = 1'b1;
            hist_wd = head_byte;
            wp_d    = wp_q + A_ONE;
            rem_d   = head.len;
            state_d = S_SHORT;
          end else begin
            out_d   = lit_sym(head.sym);
            hist_we = 1'b1;
            hist_wd = head.sym;
            wp_d    = wp_q + A_ONE;
            state_d = S_LIT;
          end
        end
      end
      S_LEN: if (fire) begin
        out_d   = dist_sym(cur_q.pos);
        state_d = S_DIST;
      end
      S_DIST: if (fire) begin
        valid_d = 1'b0;
        rem_d   = cur_q.len;
        state_d = S_COPY;
      end
      S_COPY: begin
        hist_we = 1'b1;
        hist_wd = cur_byte;
        wp_d    = wp_q + A_ONE;
        rem_d   = rem_q - CNT_WIDTH'(1);
        if (rem_q == CNT_WIDTH'(1)) state_d = S_LIT;
      end
      S_SHORT: if (fire) begin
        hist_we = 1'b1;
        wp_d    = wp_q + A_ONE;
        if (rem_q == CNT_WIDTH'(1)) begin
          out_d   = lit_sym(cur_q.sym);
          hist_wd = cur_q.sym;
          state_d = S_LIT;
        end else begin
          out_d   = lit_sym(cur_byte);
          hist_wd = cur_byte;
          rem_d   = rem_q - CNT_WIDTH'(1);
        end
      end
      S_LIT: begin
        if (!valid_q) begin
          out_d   = lit_sym(cur_q.sym);
          valid_d = 1'b1;
          hist_we = 1'b1;
          hist_wd = cur_q.sym;
          wp_d    = wp_q + A_ONE;
        end else if (fire) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_EOB: if (fire) begin
        valid_d  = 1'b0;
        wp_d     = '0;
        eob_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, FIFO pointers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      wp_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      wp_q    <= wp_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_q | (output_enable & ~push_ok);
      if (pop)     rd_q <= rd_q + PTR_ONE;
      if (push_ok) wr_q <= wr_q + PTR_ONE;
    end
  end

`ifdef LZ77_MAPPER_EOB_EN
  // Flush bookkeeping. This counts the tokens queued before the flush so they
  // drain ahead of the EOB symbol.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend_q <= 1'b0;
      flush_left_q <= '0;
    end else if (flush) begin
      flush_pend_q <= 1'b1;
      flush_left_q <= cnt_d;
    end else if (eob_done) begin
      flush_pend_q <= 1'b0;
    end else if (pop && flush_left_q != '0) begin
      flush_left_q <= flush_left_q - CW'(1);
    end
  end
`endif

  assign sym_valid     = valid_q;
  assign sym_is_dist   = out_q.is_dist;
  assign sym_code      = out_q.code;
  assign sym_extra     = out_q.extra;
  assign sym_extra_len = out_q.elen;
  assign fifo_overflow = ovf_q;

endmodule

// File: tb/tb_lz77_deflate_mapper.sv
// tb_lz77_deflate_mapper
// Scoreboard bench for lz77_deflate_mapper. A byte-level model of the history
// window produces the expected symbols, which are queued as tokens are driven.
// Define LZ77_MAPPER_EOB_EN to also cover the flush / end-of-block path.
module tb_lz77_deflate_mapper;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       output_enable = 1'b0;
  logic [4:0] match_position = '0;
  logic [4:0] match_length = '0;
  logic [7:0] next_symbol = '0;
  logic       sym_ready = 1'b1;
  logic       sym_valid, sym_is_dist, fifo_overflow;
  logic [8:0] sym_code;
  logic [4:0] sym_extra;
  logic [2:0] sym_extra_len;
`ifdef LZ77_MAPPER_EOB_EN
  logic       flush = 1'b0;
`endif

  lz77_deflate_mapper dut (
    .clk            (clk),
    .rst            (rst),
    .output_enable  (output_enable),
    .match_position (match_position),
    .match_length   (match_length),
    .next_symbol    (next_symbol),
`ifdef LZ77_MAPPER_EOB_EN
    .flush          (flush),
`endif
    .sym_valid      (sym_valid),
    .sym_ready      (sym_ready),
    .sym_is_dist    (sym_is_dist),
    .sym_code       (sym_code),
    .sym_extra      (sym_extra),
    .sym_extra_len  (sym_extra_len),
    .fifo_overflow  (fifo_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // RFC1951 base tables
  int lbase [16] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 15, 17, 19, 23, 27, 31};
  int leb   [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
  int dbase [12] = '{1, 2, 3, 4, 5, 7, 9, 13, 17, 25, 33, 49};
  int deb   [12] = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4};

  logic [17:0] exp_q [$];
  logic [7:0]  m_hist [32];
  logic [4:0]  m_wp = '0;
  bit          rand_ready = 1'b0;

  function automatic logic [17:0] pack(input int isd, input int code, input int extra, input int elen);
    return {isd[0], code[8:0], extra[4:0], elen[2:0]};
  endfunction

  function automatic logic [17:0] len_exp(input int len);
    int s = 0;
    for (int i = 0; i < 16; i++) if (len >= lbase[i]) s = i;
    return pack(0, 257 + s, len - lbase[s], leb[s]);
  endfunction

  function automatic logic [17:0] dist_exp(input int d);
    int s = 0;
    for (int i = 0; i < 12; i++) if (d >= dbase[i]) s = i;
    return pack(1, s, d - dbase[s], deb[s]);
  endfunction

  function automatic logic [4:0] src(input int d);
    int a = (int'(m_wp) - d) & 31;
    return a[4:0];
  endfunction

  task automatic model_tok(input int pos, input int len, input int sym);
    int d = pos + 1;
    logic [7:0] b;
    if (len >= 3) begin
      exp_q.push_back(len_exp(len));
      exp_q.push_back(dist_exp(d));
      for (int i = 0; i < len; i++) begin
        m_hist[m_wp] = m_hist[src(d)];
        m_wp++;
      end
    end else begin
      for (int i = 0; i < len; i++) begin
        b = m_hist[src(d)];
        exp_q.push_back(pack(0, int'(b), 0, 0));
        m_hist[m_wp] = b;
        m_wp++;
      end
    end
    b = sym[7:0];
    exp_q.push_back(pack(0, int'(b), 0, 0));
    m_hist[m_wp] = b;
    m_wp++;
  endtask

  // Called at posedge+1. This drives one token strobe and returns at posedge+1.
  task automatic send_tok(input int pos, input int len, input int sym, input bit modeled = 1'b1);
    match_position = pos[4:0];
    match_length   = len[4:0];
    next_symbol    = sym[7:0];
    output_enable  = 1'b1;
    if (modeled) model_tok(pos, len, sym);
    @(posedge clk); #1;
    output_enable = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Monitor: sample on the falling edge, compare transfers, check stall stability
  logic [18:0] prev_out;
  logic [17:0] mon_exp;
  bit          prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold", {sym_valid, sym_is_dist, sym_code, sym_extra, sym_extra_len}, prev_out);
      if (sym_valid && sym_ready) begin
        if (exp_q.size() == 0) begin
          check("queue_empty_on_sym", exp_q.size(), 1);
        end else begin
          mon_exp = exp_q.pop_front();
          check("sym", {sym_is_dist, sym_code, sym_extra, sym_extra_len}, mon_exp);
        end
      end
      prev_stall = sym_valid && !sym_ready;
      prev_out   = {sym_valid, sym_is_dist, sym_code, sym_extra, sym_extra_len};
    end
  end

  // Random downstream readiness while enabled
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) sym_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) m_hist[i] = '0;
    #12;
    check("rst_valid", sym_valid, 0);
    check("rst_ovf", fifo_overflow, 0);
    check("rst_code", sym_code, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single literal plus first-symbol latency
    send_tok(0, 0, "a");
    check("lat_edge1", sym_valid, 0);
    @(posedge clk); #1;
    check("lat_edge2", sym_valid, 1);
    check("lit_a_code", sym_code, 97);
    wait_drain();

    // A run of 16 'a' bytes followed by '$'
    send_tok(0, 0, "a");
    send_tok(0, 15, "$");
    wait_drain();

    // Short match re-expanded into literals
    send_tok(0, 0, "b");
    send_tok(0, 0, "e");
    send_tok(0, 0, "t");
    send_tok(2, 2, "x");
    wait_drain();
    send_tok(0, 2, "z");
    wait_drain();

    // Fill the whole window with bursts of 4 back-to-back literals
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) send_tok(0, 0, int'($urandom_range(0, 255)));
      wait_drain();
    end

    // Length and distance bucket edges
    send_tok(0, 3, "A");  wait_drain();
    send_tok(4, 10, "B"); wait_drain();
    send_tok(31, 31, "C"); wait_drain();
    send_tok(6, 11, "D"); wait_drain();
    send_tok(16, 18, "E"); wait_drain();
    send_tok(3, 1, "F");  wait_drain();

    // Random tokens with random downstream stalls
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send_tok(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
      wait_drain();
    end
    rand_ready = 1'b0;
    sym_ready  = 1'b1;
    @(posedge clk); #1;

    // Backpressure: 6 strobes into a stalled output. One token sits in the
    // output register and 4 fill the FIFO, so the 6th is dropped.
    sym_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_tok(0, 0, 65 + i, i < 5);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("ovf_set", fifo_overflow, 1);
    check("stall_valid", sym_valid, 1);
    check("stall_code", sym_code, 65);
    sym_ready = 1'b1;
    wait_drain();
    check("ovf_sticky", fifo_overflow, 1);

    // Asynchronous reset mid-cycle while a symbol is pending
    sym_ready = 1'b0;
    send_tok(0, 0, "Q");
    @(posedge clk); #1;
    check("pre_rst_valid", sym_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", sym_valid, 0);
    check("arst_ovf", fifo_overflow, 0);
    exp_q.delete();
    m_wp = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    sym_ready = 1'b1;

    // History pointer restarts at 0 after reset
    send_tok(1, 2, "R");
    wait_drain();
    check("post_rst_ovf", fifo_overflow, 0);

`ifdef LZ77_MAPPER_EOB_EN
    // Flush after two literals. The token sent after the flush queues behind the EOB.
    send_tok(0, 0, "a");
    send_tok(0, 0, "b");
    flush = 1'b1;
    exp_q.push_back(pack(0, 256, 0, 0));
    m_wp = '0;
    @(posedge clk); #1;
    flush = 1'b0;
    send_tok(0, 0, "c");
    wait_drain();
    send_tok(0, 1, "k");
    wait_drain();
`endif

    repeat (3) begin
      @(posedge clk); #1;
    end
    check("final_idle", sym_valid, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
